// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronizes and debounces a raw button pin and
// emits single-cycle press / release / short-press / long-press events.
module button_debounce_pulse #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 100_000_000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HC_W = $clog2(LONG_CYCLES);
   localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
   localparam logic [HC_W-1:0] HC_MAX  = HC_W'(LONG_CYCLES - 32'd1);
   localparam logic [HC_W-1:0] HC_ZERO = {HC_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   logic            btn_n_s;
   logic            sync1_r;
   logic            btn_sync_r;
   logic [DB_W-1:0] db_cnt_r;
   logic            pressed_r;
   logic [HC_W-1:0] hold_cnt_r;
   state_t          state_r;
   state_t          next_state_s;
   logic            press_s;
   logic            release_s;
   logic            short_s;
   logic            long_s;
   logic            press_pulse_r;
   logic            release_pulse_r;
   logic            short_pulse_r;
   logic            long_pulse_r;

   assign btn_n_s = btn_in ^ BTN_ACTIVE_LOW;

   // Two-flop synchronizer for the asynchronous button pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r    <= 1'b0;
         btn_sync_r <= 1'b0;
      end else begin
         sync1_r    <= btn_n_s;
         btn_sync_r <= sync1_r;
      end
   end

   // Debounce: accept a new level only after an unbroken run of disagreeing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_r  <= DB_ZERO;
         pressed_r <= 1'b0;
      end else if (btn_sync_r == pressed_r) begin
         db_cnt_r  <= DB_ZERO;
      end else if (db_cnt_r == DB_MAX) begin
         pressed_r <= btn_sync_r;
         db_cnt_r  <= DB_ZERO;
      end else begin
         db_cnt_r  <= db_cnt_r + DB_W'(1);
      end
   end

   // Event FSM next-state and pulse decode; a release outranks a long press
   always_comb begin
      next_state_s = state_r;
      press_s      = 1'b0;
      release_s    = 1'b0;
      short_s      = 1'b0;
      long_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pressed_r) begin
               next_state_s = ST_PRESSED;
               press_s      = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_PRESSED: begin
            if (!pressed_r) begin
               next_state_s = ST_IDLE;
               release_s    = 1'b1;
               short_s      = 1'b1;
            end else if (hold_cnt_r == HC_MAX) begin
               next_state_s = ST_LONG;
               long_s       = 1'b1;
            end else begin
               next_state_s = ST_PRESSED;
            end
         end
         ST_LONG: begin
            if (!pressed_r) begin
               next_state_s = ST_IDLE;
               release_s    = 1'b1;
            end else begin
               next_state_s = ST_LONG;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered event pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= ST_IDLE;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         short_pulse_r   <= 1'b0;
         long_pulse_r    <= 1'b0;
      end else begin
         state_r         <= next_state_s;
         press_pulse_r   <= press_s;
         release_pulse_r <= release_s;
         short_pulse_r   <= short_s;
         long_pulse_r    <= long_s;
      end
   end

   // Hold timer: cleared on entering PRESSED, frozen outside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= HC_ZERO;
      end else if ((state_r == ST_IDLE) && (next_state_s == ST_PRESSED)) begin
         hold_cnt_r <= HC_ZERO;
      end else if ((state_r == ST_PRESSED) && (next_state_s == ST_PRESSED)) begin
         hold_cnt_r <= hold_cnt_r + HC_W'(1);
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end

   assign pressed       = pressed_r;
   assign press_pulse   = press_pulse_r;
   assign release_pulse = release_pulse_r;
   assign short_pulse   = short_pulse_r;
   assign long_pulse    = long_pulse_r;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Scoreboard bench for button_debounce_pulse: expected pulse events are queued
// with their cycle when stimulus is driven and matched as the DUTs emit them.
module tb_button_debounce_pulse;

   localparam int DB = 4;
   localparam int LC = 10;
   localparam logic [3:0] P_PRESS = 4'b0001;
   localparam logic [3:0] P_REL   = 4'b0010;
   localparam logic [3:0] P_SHORT = 4'b0100;
   localparam logic [3:0] P_LONG  = 4'b1000;

   typedef struct {
      int         cyc;
      logic [3:0] p;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic btn_a = 1'b0;
   logic btn_b = 1'b1;
   logic pressed_a, press_a, rel_a, short_a, long_a;
   logic pressed_b, press_b, rel_b, short_b, long_b;

   int  cyc   = 0;
   int  n_vec = 0;
   int  n_err = 0;
   ev_t q_a[$];
   ev_t q_b[$];
   ev_t e_a, e_b;
   logic [3:0] p_a, p_b;

   button_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .BTN_ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .pressed(pressed_a),
      .press_pulse(press_a), .release_pulse(rel_a), .short_pulse(short_a), .long_pulse(long_a)
   );

   button_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .BTN_ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .pressed(pressed_b),
      .press_pulse(press_b), .release_pulse(rel_b), .short_pulse(short_b), .long_pulse(long_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_a(input int c, input logic [3:0] p);
      ev_t e;
      e.cyc = c;
      e.p   = p;
      q_a.push_back(e);
   endtask

   task automatic expect_b(input int c, input logic [3:0] p);
      ev_t e;
      e.cyc = c;
      e.p   = p;
      q_b.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Match every observed pulse on dut_a against the next queued expectation
   always @(negedge clk) begin
      p_a = {long_a, short_a, rel_a, press_a};
      if (p_a != 4'b0000) begin
         if (q_a.size() == 0) begin
            chk_eq("a_unexpected", 32'(p_a), 32'd0);
         end else begin
            e_a = q_a.pop_front();
            chk_eq("a_cycle", cyc, e_a.cyc);
            chk_eq("a_pulses", 32'(p_a), 32'(e_a.p));
         end
      end
   end

   // Same matching for the active-low instance
   always @(negedge clk) begin
      p_b = {long_b, short_b, rel_b, press_b};
      if (p_b != 4'b0000) begin
         if (q_b.size() == 0) begin
            chk_eq("b_unexpected", 32'(p_b), 32'd0);
         end else begin
            e_b = q_b.pop_front();
            chk_eq("b_cycle", cyc, e_b.cyc);
            chk_eq("b_pulses", 32'(p_b), 32'(e_b.p));
         end
      end
   end

   initial begin
      int t0;
      int t1;
      int h;
      int l;
      int spent;

      #2;
      chk_eq("rst_pressed_a", pressed_a, 0);
      chk_eq("rst_pulses_a", {long_a, short_a, rel_a, press_a}, 0);
      chk_eq("rst_pressed_b", pressed_b, 0);
      step(3);
      rst_n = 1'b1;
      step(2);

      // Clean press held into a long press, then released
      t0 = cyc;
      btn_a = 1'b1;
      expect_a(t0 + 7, P_PRESS);
      expect_a(t0 + 17, P_LONG);
      step(5);
      chk_eq("clean_pressed_e5", pressed_a, 0);
      step(1);
      chk_eq("clean_pressed_e6", pressed_a, 1);
      step(24);
      btn_a = 1'b0;
      t1 = cyc;
      expect_a(t1 + 7, P_REL);
      step(12);
      chk_eq("clean_sb_empty", q_a.size(), 0);
      chk_eq("clean_pressed_end", pressed_a, 0);

      // Bounce: high runs of 1..3 cycles never get accepted
      spent = 0;
      while (spent < 20) begin
         h = $urandom_range(3, 1);
         btn_a = 1'b1;
         for (int i = 0; i < h; i++) begin
            @(negedge clk);
            chk_eq("bounce_pressed", pressed_a, 0);
         end
         l = $urandom_range(2, 1);
         btn_a = 1'b0;
         for (int i = 0; i < l; i++) begin
            @(negedge clk);
            chk_eq("bounce_pressed", pressed_a, 0);
         end
         spent = spent + h + l;
      end
      step(10);
      chk_eq("bounce_pressed_end", pressed_a, 0);
      chk_eq("bounce_sb_empty", q_a.size(), 0);

      // Short press
      t0 = cyc;
      btn_a = 1'b1;
      expect_a(t0 + 7, P_PRESS);
      step(8);
      btn_a = 1'b0;
      expect_a(t0 + 15, P_REL | P_SHORT);
      step(12);
      chk_eq("short_sb_empty", q_a.size(), 0);

      // Release lands exactly when the hold timer hits its limit: release wins
      t0 = cyc;
      btn_a = 1'b1;
      expect_a(t0 + 7, P_PRESS);
      step(10);
      btn_a = 1'b0;
      expect_a(t0 + 17, P_REL | P_SHORT);
      step(14);
      chk_eq("collide_sb_empty", q_a.size(), 0);

      // One cycle later the long press qualifies first
      t0 = cyc;
      btn_a = 1'b1;
      expect_a(t0 + 7, P_PRESS);
      step(11);
      btn_a = 1'b0;
      expect_a(t0 + 17, P_LONG);
      expect_a(t0 + 18, P_REL);
      step(14);
      chk_eq("late_rel_sb_empty", q_a.size(), 0);

      // Reset while in LONG with the button still held
      t0 = cyc;
      btn_a = 1'b1;
      expect_a(t0 + 7, P_PRESS);
      expect_a(t0 + 17, P_LONG);
      step(20);
      chk_eq("pre_rst_pressed", pressed_a, 1);
      rst_n = 1'b0;
      #1;
      chk_eq("async_rst_pressed", pressed_a, 0);
      chk_eq("async_rst_pulses", {long_a, short_a, rel_a, press_a}, 0);
      chk_eq("pre_rst_sb_empty", q_a.size(), 0);
      step(2);
      rst_n = 1'b1;
      t0 = cyc;
      expect_a(t0 + 7, P_PRESS);
      step(8);
      btn_a = 1'b0;
      expect_a(t0 + 15, P_REL | P_SHORT);
      step(12);
      chk_eq("rst_sb_empty", q_a.size(), 0);

      // Active-low instance: idle-high pin, pressed by driving it low
      t0 = cyc;
      btn_b = 1'b0;
      expect_b(t0 + 7, P_PRESS);
      expect_b(t0 + 17, P_LONG);
      step(20);
      chk_eq("alow_pressed", pressed_b, 1);
      btn_b = 1'b1;
      expect_b(t0 + 27, P_REL);
      step(12);
      chk_eq("alow_sb_empty", q_b.size(), 0);
      chk_eq("alow_pressed_end", pressed_b, 0);
      chk_eq("final_a_sb_empty", q_a.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
